dot_matrix_ctrl: RTL and testbench

Sequencer for the 8x8 LED dot-matrix driver (MAX7219-class, 16-bit serial frames on `clk_out`/`data_out`/`load`). After reset it sends the driver's initialisation words. After that, on each `start` request it streams eight row registers from a 64-bit frame buffer. It sits between the keypad/application logic, which owns the frame contents, and the dot-matrix pins. It is the only block that drives those pins.

---
 rtl/dot_pkg.sv | 50 +++++
 rtl/dot_shift16.sv | 70 +++++++
 rtl/dot_matrix_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dot_matrix_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - register map, sequencer states and init table for the dot-matrix controller
package dot_pkg;

  // Driver register addresses
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

  localparam int INIT_WORDS = 5;

  typedef enum logic [2:0] {
    INIT_LOAD,
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    LOAD_PULSE,
    GAP,
    NEXT
  } state_t;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  // Power-up register programming, sent in index order 0..4
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    logic [15:0] w;
    case (idx)
      3'd0:    w = make_word(ADDR_DISPTEST, 8'h00);
      3'd1:    w = make_word(ADDR_DECODE, 8'h00);
      3'd2:    w = make_word(ADDR_INTENSITY, {4'h0, inten});
      3'd3:    w = make_word(ADDR_SCANLIM, 8'h07);
      default: w = make_word(ADDR_SHUTDOWN, 8'h01);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dot_shift16.sv
// rtl/dot_shift16.sv - 16-bit MSB-first serializer with LOAD framing
module dot_shift16 #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [15:0] word,
  output logic        clk_out,
  output logic        data_out,
  output logic        load,
  output logic        ack
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic        active;
  logic        phase_hi;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] sh;

  // Last cycle of bit 0 high phase: the word is complete
  assign ack = active && phase_hi && (cnt == DIV_M1) && (bit_cnt == 4'd0);

  // Bit timing: data changes at the start of each low phase, load rises after bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      phase_hi <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      clk_out  <= 1'b0;
      data_out <= 1'b0;
      load     <= 1'b1;
    end else if (go) begin
      active   <= 1'b1;
      phase_hi <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= 4'd15;
      sh       <= word[14:0];
      clk_out  <= 1'b0;
      data_out <= word[15];
      load     <= 1'b0;
    end else if (active) begin
      if (cnt == DIV_M1) begin
        cnt <= '0;
        if (!phase_hi) begin
          phase_hi <= 1'b1;
          clk_out  <= 1'b1;
        end else if (bit_cnt == 4'd0) begin
          active   <= 1'b0;
          phase_hi <= 1'b0;
          clk_out  <= 1'b0;
          load     <= 1'b1;
        end else begin
          phase_hi <= 1'b0;
          clk_out  <= 1'b0;
          bit_cnt  <= bit_cnt - 4'd1;
          data_out <= sh[14];
          sh       <= {sh[13:0], 1'b0};
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dot_matrix_ctrl.sv
// rtl/dot_matrix_ctrl.sv - init/refresh sequencer for 8x8 dot-matrix driver; optional DOT_INTENSITY_EN
module dot_matrix_ctrl
  import dot_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [3:0]  INTENSITY = 4'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] row_data,
`ifdef DOT_INTENSITY_EN
  input  logic [3:0]  intensity,
`endif
  output logic        busy,
  output logic        done,
  output logic        clk_out,
  output logic        data_out,
  output logic        load
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_M2 = 8'(CLK_DIV - 2);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [3:0]  widx;
  logic        init_mode;
  logic        pending;
  logic [63:0] frame;
  logic        with_prefix;
  logic [3:0]  cur_int;
  logic        last_word;
  logic        refresh_begin;
  logic        advance;
  logic        go;
  logic        ack;
  logic [15:0] word;
  logic [2:0]  row_sel;

  // A word is launched from INIT_LOAD (init table) or LATCH (refresh)
  assign go            = (state == INIT_LOAD) || (state == LATCH);
  assign advance       = (state == NEXT) && !last_word;
  assign refresh_begin = ((state == IDLE) && start) ||
                         ((state == NEXT) && last_word && (pending || start));

  // Final word index depends on the running sequence
  always_comb begin
    last_word = 1'b0;
    if (init_mode)        last_word = (widx == 4'(INIT_WORDS - 1));
    else if (with_prefix) last_word = (widx == 4'd8);
    else                  last_word = (widx == 4'd7);
  end

  // Word mux: init table, optional brightness prefix, then the eight rows
  always_comb begin
    row_sel = '0;
    word    = '0;
    if (init_mode) begin
      word = init_word(widx[2:0], INTENSITY);
    end else if (with_prefix && (widx == 4'd0)) begin
      word = make_word(ADDR_INTENSITY, {4'h0, cur_int});
    end else begin
      row_sel = with_prefix ? 3'(widx - 4'd1) : widx[2:0];
      word    = make_word(ADDR_DIGIT0 + {1'b0, row_sel}, frame[{row_sel, 3'b000} +: 8]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT_LOAD;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      INIT_LOAD:  state_next = SHIFT_LO;
      IDLE:       if (start) state_next = LATCH;
      LATCH:      state_next = SHIFT_LO;
      SHIFT_LO:   if (cnt == DIV_M1) state_next = SHIFT_HI;
      SHIFT_HI: begin
        if (ack)                 state_next = LOAD_PULSE;
        else if (cnt == DIV_M1)  state_next = SHIFT_LO;
      end
      LOAD_PULSE: if (cnt == DIV_M1) state_next = GAP;
      // GAP plus the NEXT cycle together hold load high for CLK_DIV cycles
      GAP:        if (cnt == DIV_M2) state_next = NEXT;
      NEXT: begin
        if (!last_word)              state_next = init_mode ? INIT_LOAD : LATCH;
        else if (pending || start)   state_next = LATCH;
        else                         state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

  // Phase counter restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else                          cnt <= cnt + 8'd1;
  end

  // Sequence bookkeeping, request merging and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      widx      <= '0;
      init_mode <= 1'b1;
      pending   <= 1'b0;
      frame     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == GAP) && (state_next == NEXT) && !init_mode && last_word;
      busy <= (state_next != IDLE) &&
              !((state_next == NEXT) && last_word && !(pending || start));
      if (refresh_begin) begin
        frame     <= row_data;
        widx      <= '0;
        init_mode <= 1'b0;
        pending   <= 1'b0;
      end else begin
        if (advance) widx <= widx + 4'd1;
        if ((state == NEXT) && last_word) begin
          init_mode <= 1'b0;
          pending   <= 1'b0;
        end else if (start && (state != IDLE)) begin
          pending <= 1'b1;
        end
      end
    end
  end

`ifdef DOT_INTENSITY_EN
  logic [3:0] last_int;

  // Prefix a brightness word only when the requested level differs from the last one sent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_int     <= INTENSITY;
      last_int    <= INTENSITY;
      with_prefix <= 1'b0;
    end else if (refresh_begin) begin
      cur_int     <= intensity;
      last_int    <= intensity;
      with_prefix <= (intensity != last_int);
    end
  end
`else
  assign with_prefix = 1'b0;
  assign cur_int     = INTENSITY;
`endif

  dot_shift16 #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .word     (word),
    .clk_out  (clk_out),
    .data_out (data_out),
    .load     (load),
    .ack      (ack)
  );

endmodule

// File: tb/tb_dot_matrix_ctrl.sv
// tb/tb_dot_matrix_ctrl.sv - directed self-checking bench for dot_matrix_ctrl
module tb_dot_matrix_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] row_data = '0;
  logic        busy;
  logic        done;
  logic        clk_out;
  logic        data_out;
  logic        load;
`ifdef DOT_INTENSITY_EN
  logic [3:0]  intensity = 4'd8;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bits = 0;
  int t0 = 0;
  logic [15:0] shreg = '0;
  logic        prev_clk = 1'b0;
  logic        prev_load = 1'b1;
  logic [15:0] got[$];

  logic [15:0] init_exp [5] = '{16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};
  logic [15:0] row_exp  [8] = '{16'h0181, 16'h0242, 16'h0324, 16'h0418,
                                16'h0518, 16'h0624, 16'h0742, 16'h0881};

  localparam logic [63:0] PAT_A = 64'h1111_2222_3333_4444;
  localparam logic [63:0] PAT_B = 64'h8877_6655_4433_2211;
  localparam logic [63:0] PAT_C = 64'h0F0F_F0F0_55AA_33CC;
  localparam logic [63:0] PAT_D = 64'h0102_0304_0506_0708;

  dot_matrix_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .row_data (row_data),
`ifdef DOT_INTENSITY_EN
    .intensity(intensity),
`endif
    .busy     (busy),
    .done     (done),
    .clk_out  (clk_out),
    .data_out (data_out),
    .load     (load)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Driver model: shift on clk_out rise while load is low, latch on load rise
  always @(negedge clk) begin
    if (reset) begin
      bits      = 0;
      prev_clk  = 1'b0;
      prev_load = 1'b1;
    end else begin
      if (!load && clk_out && !prev_clk) begin
        shreg = {shreg[14:0], data_out};
        bits++;
      end
      if (load && !prev_load) begin
        if (bits == 16) got.push_back(shreg);
        bits = 0;
      end
      if (done) done_cnt++;
      prev_clk  = clk_out;
      prev_load = load;
    end
  end

  function automatic logic [15:0] exp_row(input logic [63:0] d, input int r);
    logic [63:0] s;
    s = d >> (8 * r);
    return {4'h0, 4'(r + 1), s[7:0]};
  endfunction

  function automatic logic [15:0] gw(input int i);
    if (i < got.size()) return got[i];
    return 16'hxxxx;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < limit);
    check(tag, done, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_load", load, 1'b1);
    check("rst_data_out", data_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Init sequence after release
    reset = 1'b0;
    check("busy_c0", busy, 1'b0);
    tick(1);
    check("busy_c1", busy, 1'b1);
    check("load_c1", load, 1'b0);
    tick(682);
    check("busy_c683", busy, 1'b1);
    tick(2);
    check("busy_c685", busy, 1'b0);
    check("init_count", got.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("init_w%0d", i), gw(i), init_exp[i]);
    check("init_no_done", done_cnt, 0);

    // Plain refresh; later row_data changes must not leak in
    got.delete();
    done_cnt = 0;
    row_data = 64'h8142_2418_1824_4281;
    t0 = cyc;
    pulse_start();
    row_data = 64'hDEAD_BEEF_0000_FFFF;
    wait_done("refresh_done", 1200);
    check("refresh_latency", cyc - t0, 1096);
    check("refresh_busy_at_done", busy, 1'b0);
    tick(1);
    check("done_one_cycle", done, 1'b0);
    check("refresh_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("row_w%0d", i), gw(i), row_exp[i]);

    // start during init chains straight into a refresh
    reset = 1'b1;
    tick(2);
    got.delete();
    row_data = PAT_D;
    reset = 1'b0;
    tick(10);
    pulse_start();
    tick(673);
    check("chain_busy_c684", busy, 1'b1);
    tick(1);
    check("chain_init_words", got.size(), 5);
    done_cnt = 0;
    wait_done("chain_done", 1200);
    check("chain_done_cyc", cyc, 1780);
    tick(5);
    check("chain_done_cnt", done_cnt, 1);
    check("chain_busy_idle", busy, 1'b0);
    check("chain_count", got.size(), 13);
    for (int i = 0; i < 8; i++) check($sformatf("chain_w%0d", i), gw(i + 5), exp_row(PAT_D, i));

    // Three requests during a refresh merge into one follow-up refresh
    got.delete();
    done_cnt = 0;
    row_data = PAT_A;
    t0 = cyc;
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      tick(99);
      if (k == 3) row_data = PAT_B;
      pulse_start();
    end
    wait_done("multi_done1", 1200);
    check("multi_lat1", cyc - t0, 1096);
    check("multi_busy1", busy, 1'b1);
    wait_done("multi_done2", 1200);
    check("multi_lat2", cyc - t0, 2192);
    check("multi_busy2", busy, 1'b0);
    tick(300);
    check("multi_done_cnt", done_cnt, 2);
    check("multi_count", got.size(), 16);
    for (int i = 0; i < 8; i++) check($sformatf("multi_a%0d", i), gw(i), exp_row(PAT_A, i));
    for (int i = 0; i < 8; i++) check($sformatf("multi_b%0d", i), gw(i + 8), exp_row(PAT_B, i));

    // Reset at bit 7 of the third refresh word
    row_data = PAT_C;
    t0 = cyc;
    pulse_start();
    got.delete();
    tick(339);
    check("mid_load_low", load, 1'b0);
    check("mid_clk_low", clk_out, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_clk_out", clk_out, 1'b0);
    check("mid_rst_load", load, 1'b1);
    check("mid_rst_data_out", data_out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_words", got.size(), 2);
    check("mid_w1", gw(1), exp_row(PAT_C, 1));
    tick(2);
    done_cnt = 0;
    got.delete();
    reset = 1'b0;
    tick(700);
    check("reinit_count", got.size(), 5);
    check("reinit_w0", gw(0), 16'h0F00);
    check("reinit_w4", gw(4), 16'h0C01);
    check("reinit_busy", busy, 1'b0);
    check("reinit_no_done", done_cnt, 0);

`ifdef DOT_INTENSITY_EN
    // Brightness change prefixes the refresh; repeating it does not
    got.delete();
    row_data  = 64'h0123_4567_89AB_CDEF;
    intensity = 4'hF;
    t0 = cyc;
    pulse_start();
    intensity = 4'h8;
    wait_done("int_done1", 1400);
    check("int_lat1", cyc - t0, 1233);
    tick(5);
    check("int_count1", got.size(), 9);
    check("int_prefix", gw(0), 16'h0A0F);
    check("int_row0", gw(1), exp_row(64'h0123_4567_89AB_CDEF, 0));
    check("int_row7", gw(8), exp_row(64'h0123_4567_89AB_CDEF, 7));
    got.delete();
    intensity = 4'hF;
    t0 = cyc;
    pulse_start();
    wait_done("int_done2", 1400);
    check("int_lat2", cyc - t0, 1096);
    tick(5);
    check("int_count2", got.size(), 8);
    check("int2_row0", gw(0), exp_row(64'h0123_4567_89AB_CDEF, 0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
